// File: rtl/csr_dec_mul_pkg.sv
// Shared constants and width/saturation helpers for the csr_dec multiplier pipe.
package csr_dec_mul_pkg;

    localparam int NUM_STAGE_MIN = 2;
    localparam int NUM_STAGE_MAX = 8;

    function automatic int prod_width(input int w0, input int w1);
        return w0 + w1;
    endfunction

    // Callers truncate to their result width; bit patterns are right-aligned.
    function automatic logic [63:0] sat_max(input int w, input bit sgn);
        if (sgn)
            return (64'd1 << (w - 1)) - 64'd1;
        else if (w >= 64)
            return '1;
        else
            return (64'd1 << w) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int w, input bit sgn);
        return sgn ? (~64'd0 << (w - 1)) : 64'd0;
    endfunction

endpackage

// File: rtl/csr_dec_mul_narrow.sv
// Combinational round / shift / narrow of the full product into the output width.
// CSR_DEC_MUL_PIPE_SAT_EN selects saturation with an overflow flag; otherwise results wrap.
module csr_dec_mul_narrow
    import csr_dec_mul_pkg::*;
#(
    parameter int PW         = 28,
    parameter int DOUT_WIDTH = 14,
    parameter int SIGNED     = 1,
    parameter int SHIFT      = 0,
    parameter int ROUND      = 0
) (
    input  logic [PW-1:0]         i_prod,
    output logic [DOUT_WIDTH-1:0] o_dout
`ifdef CSR_DEC_MUL_PIPE_SAT_EN
    ,
    output logic                  o_ovf
`endif
);

    // One guard bit above the product so rounding never wraps.
    localparam int SW = (PW + 1 > DOUT_WIDTH + 1) ? PW + 1 : DOUT_WIDTH + 1;
    localparam logic [SW-1:0] RND = (ROUND != 0 && SHIFT > 0) ?
                                    (SW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

    logic [SW-1:0] w_ext;
    logic [SW-1:0] w_t;

    assign w_ext = (SIGNED != 0) ? {{(SW-PW){i_prod[PW-1]}}, i_prod}
                                 : {{(SW-PW){1'b0}}, i_prod};
    assign w_t   = w_ext + RND;

`ifdef CSR_DEC_MUL_PIPE_SAT_EN
    localparam logic [DOUT_WIDTH-1:0] SAT_MAX = DOUT_WIDTH'(sat_max(DOUT_WIDTH, SIGNED != 0));
    localparam logic [DOUT_WIDTH-1:0] SAT_MIN = DOUT_WIDTH'(sat_min(DOUT_WIDTH, SIGNED != 0));

    logic [SW-1:0] w_s;

    always_comb begin
        if (SIGNED != 0) begin
            w_s   = $signed(w_t) >>> SHIFT;
            o_ovf = !((&w_s[SW-1:DOUT_WIDTH-1]) || !(|w_s[SW-1:DOUT_WIDTH-1]));
        end else begin
            w_s   = w_t >> SHIFT;
            o_ovf = |w_s[SW-1:DOUT_WIDTH];
        end
        o_dout = w_s[DOUT_WIDTH-1:0];
        if (o_ovf)
            o_dout = (SIGNED != 0 && w_s[SW-1]) ? SAT_MIN : SAT_MAX;
    end
`else
    always_comb begin
        if (SIGNED != 0)
            o_dout = DOUT_WIDTH'($signed(w_t) >>> SHIFT);
        else
            o_dout = DOUT_WIDTH'(w_t >> SHIFT);
    end
`endif

endmodule

// File: rtl/csr_dec_mul_pipe.sv
// Pipelined multiplier: operand stage, NUM_STAGE-2 product stages, registered narrow stage.
// CSR_DEC_MUL_PIPE_SAT_EN enables output saturation and the ovf flag.
module csr_dec_mul_pipe
    import csr_dec_mul_pkg::*;
#(
    parameter int DIN0_WIDTH = 14,
    parameter int DIN1_WIDTH = 14,
    parameter int DOUT_WIDTH = 14,
    parameter int NUM_STAGE  = 4,
    parameter int SIGNED     = 1,
    parameter int SHIFT      = 0,
    parameter int ROUND      = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  flush,
    input  logic                  din_valid,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    output logic                  dout_valid,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  ovf,
    output logic                  busy
);

    localparam int PW   = prod_width(DIN0_WIDTH, DIN1_WIDTH);
    localparam int NMID = NUM_STAGE - 2;

    if (NUM_STAGE < NUM_STAGE_MIN || NUM_STAGE > NUM_STAGE_MAX) begin : g_bad_stage
        $error("csr_dec_mul_pipe: NUM_STAGE must be within 2..8");
    end

    logic [NUM_STAGE:1]    r_vld_pipe;
    logic [DIN0_WIDTH-1:0] r_a;
    logic [DIN1_WIDTH-1:0] r_b;
    logic [DOUT_WIDTH-1:0] r_dout;
    logic [PW-1:0]         w_a;
    logic [PW-1:0]         w_b;
    logic [PW-1:0]         w_prod;
    logic [PW-1:0]         w_last;
    logic [DOUT_WIDTH-1:0] w_dout;

    // Extending to PW first makes the low PW bits exact for both modes.
    assign w_a    = (SIGNED != 0) ? {{DIN1_WIDTH{r_a[DIN0_WIDTH-1]}}, r_a} : {{DIN1_WIDTH{1'b0}}, r_a};
    assign w_b    = (SIGNED != 0) ? {{DIN0_WIDTH{r_b[DIN1_WIDTH-1]}}, r_b} : {{DIN0_WIDTH{1'b0}}, r_b};
    assign w_prod = w_a * w_b;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld_pipe <= '0;
            r_a        <= '0;
            r_b        <= '0;
        end else if (ce) begin
            r_vld_pipe <= flush ? '0 : {r_vld_pipe[NUM_STAGE-1:1], din_valid};
            r_a        <= din0;
            r_b        <= din1;
        end
    end

    if (NMID > 0) begin : g_mid
        logic [PW-1:0] r_prod [NMID];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int i = 0; i < NMID; i++) r_prod[i] <= '0;
            end else if (ce) begin
                r_prod[0] <= w_prod;
                for (int i = 1; i < NMID; i++) r_prod[i] <= r_prod[i-1];
            end
        end
        assign w_last = r_prod[NMID-1];
    end else begin : g_nomid
        assign w_last = w_prod;
    end

`ifdef CSR_DEC_MUL_PIPE_SAT_EN
    logic w_ovf;
    logic r_ovf;

    csr_dec_mul_narrow #(
        .PW(PW), .DOUT_WIDTH(DOUT_WIDTH), .SIGNED(SIGNED), .SHIFT(SHIFT), .ROUND(ROUND)
    ) u_narrow (
        .i_prod (w_last),
        .o_dout (w_dout),
        .o_ovf  (w_ovf)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_ovf <= 1'b0;
        else if (ce)
            r_ovf <= w_ovf;
    end
    assign ovf = r_ovf & dout_valid;
`else
    csr_dec_mul_narrow #(
        .PW(PW), .DOUT_WIDTH(DOUT_WIDTH), .SIGNED(SIGNED), .SHIFT(SHIFT), .ROUND(ROUND)
    ) u_narrow (
        .i_prod (w_last),
        .o_dout (w_dout)
    );
    assign ovf = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_dout <= '0;
        else if (ce)
            r_dout <= w_dout;
    end

    assign dout       = r_dout;
    assign dout_valid = r_vld_pipe[NUM_STAGE];
    assign busy       = |r_vld_pipe;

endmodule

// File: tb/tb_csr_dec_mul_pipe.sv
// Scoreboard bench for csr_dec_mul_pipe over four parameter sets sharing one stimulus stream.
module tb_csr_dec_mul_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ce = 1'b0;
    logic        flush = 1'b0;
    logic        din_valid = 1'b0;
    logic [13:0] din0 = '0;
    logic [13:0] din1 = '0;
    logic [3:0]  dv, bz, ov;
    logic [13:0] dq0, dq1, dq2;
    logic [15:0] dq3;

    logic [16:0] sb [4][$];
    int          n_tests = 0;
    int          n_fail = 0;
    bit          upd = 1'b0;

    always #5 clk = ~clk;

    // 0: defaults; 1: SHIFT=4; 2: SHIFT=4 ROUND=1; 3: unsigned 8x8->16, 2 stages
    csr_dec_mul_pipe dut0 (
        .clk(clk), .reset(reset), .ce(ce), .flush(flush), .din_valid(din_valid),
        .din0(din0), .din1(din1), .dout_valid(dv[0]), .dout(dq0), .ovf(ov[0]), .busy(bz[0]));
    csr_dec_mul_pipe #(.NUM_STAGE(3), .SHIFT(4), .ROUND(0)) dut1 (
        .clk(clk), .reset(reset), .ce(ce), .flush(flush), .din_valid(din_valid),
        .din0(din0), .din1(din1), .dout_valid(dv[1]), .dout(dq1), .ovf(ov[1]), .busy(bz[1]));
    csr_dec_mul_pipe #(.NUM_STAGE(3), .SHIFT(4), .ROUND(1)) dut2 (
        .clk(clk), .reset(reset), .ce(ce), .flush(flush), .din_valid(din_valid),
        .din0(din0), .din1(din1), .dout_valid(dv[2]), .dout(dq2), .ovf(ov[2]), .busy(bz[2]));
    csr_dec_mul_pipe #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(16), .NUM_STAGE(2), .SIGNED(0)) dut3 (
        .clk(clk), .reset(reset), .ce(ce), .flush(flush), .din_valid(din_valid),
        .din0(din0[7:0]), .din1(din1[7:0]), .dout_valid(dv[3]), .dout(dq3), .ovf(ov[3]), .busy(bz[3]));

    function automatic logic [16:0] model(input int i, input logic [13:0] a, input logic [13:0] b);
        longint p, s, lo, hi;
        int dw = (i == 3) ? 16 : 14;
        int sh = (i == 1 || i == 2) ? 4 : 0;
        logic [15:0] r;
        bit o;
        if (i == 3) p = longint'(a[7:0]) * longint'(b[7:0]);
        else        p = longint'($signed(a)) * longint'($signed(b));
        if (i == 2) p = p + (longint'(1) <<< (sh - 1));
        s = p >>> sh;
        if (i == 3) begin lo = 0; hi = (longint'(1) <<< dw) - 1; end
        else begin lo = -(longint'(1) <<< (dw - 1)); hi = (longint'(1) <<< (dw - 1)) - 1; end
        o = (s < lo) || (s > hi);
`ifdef CSR_DEC_MUL_PIPE_SAT_EN
        if (s > hi) s = hi;
        if (s < lo) s = lo;
`else
        o = 1'b0;
`endif
        r = s[15:0];
        if (dw == 14) r[15:14] = 2'b00;
        return {o, r};
    endfunction

    function automatic logic [16:0] obs(input int i);
        case (i)
            0:       return {ov[0], 2'b00, dq0};
            1:       return {ov[1], 2'b00, dq1};
            2:       return {ov[2], 2'b00, dq2};
            default: return {ov[3], dq3};
        endcase
    endfunction

    // Expectations enter at the accepting edge; flush and reset drop everything in flight.
    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            for (int i = 0; i < 4; i++) sb[i].delete();
            upd = 1'b0;
        end else begin
            upd = ce;
            if (ce && flush)
                for (int i = 0; i < 4; i++) sb[i].delete();
            else if (ce && din_valid)
                for (int i = 0; i < 4; i++) sb[i].push_back(model(i, din0, din1));
        end
    end

    initial begin : mon
        logic [16:0] e;
        forever begin
            @(negedge clk);
            if (reset && upd) begin
                for (int i = 0; i < 4; i++) begin
                    if (dv[i]) begin
                        n_tests++;
                        if (sb[i].size() == 0) begin
                            n_fail++;
                            $display("FAIL sb_unexpected dut%0d: got %h, expected no result", i, obs(i));
                        end else begin
                            e = sb[i].pop_front();
                            if (obs(i) !== e) begin
                                n_fail++;
                                $display("FAIL sb_result dut%0d: got %h, expected %h", i, obs(i), e);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [13:0] a, input logic [13:0] b);
        din0 = a; din1 = b; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
    endtask

    task automatic test_reset();
        ce = 1'b0; reset = 1'b0;
        repeat (2) step();
        n_tests++;
        if (dv !== 4'b0 || bz !== 4'b0 || ov !== 4'b0) begin
            n_fail++; $display("FAIL reset_flags: dv=%b busy=%b ovf=%b, expected all 0", dv, bz, ov);
        end
        n_tests++;
        if (dq0 !== 14'h0 || dq3 !== 16'h0) begin
            n_fail++; $display("FAIL reset_dout: dout0=%h dout3=%h, expected 0", dq0, dq3);
        end
        reset = 1'b1;
        step();
        ce = 1'b1;
    endtask

    task automatic test_basic();
        issue(14'd3, 14'h3FFB);
        step();
        n_tests++;
        if (dv[0] !== 1'b0 || dv[3] !== 1'b1 || dq3 !== 16'h02F1) begin
            n_fail++; $display("FAIL basic_lat2: dv0=%b dv3=%b dout3=%h, expected 0 1 02f1", dv[0], dv[3], dq3);
        end
        step();
        n_tests++;
        if (dv[0] !== 1'b0) begin n_fail++; $display("FAIL basic_early: dv0=%b, expected 0", dv[0]); end
        step();
        n_tests++;
        if (dv[0] !== 1'b1 || dq0 !== 14'h3FF1 || ov[0] !== 1'b0) begin
            n_fail++; $display("FAIL basic_result: dv=%b dout=%h ovf=%b, expected 1 3ff1 0", dv[0], dq0, ov[0]);
        end
        step();
        n_tests++;
        if (dv[0] !== 1'b0) begin n_fail++; $display("FAIL basic_pulse: dv0=%b, expected 0", dv[0]); end
    endtask

    task automatic test_wrap();
        logic [13:0] ed;
        logic        eo;
`ifdef CSR_DEC_MUL_PIPE_SAT_EN
        ed = 14'h1FFF; eo = 1'b1;
`else
        ed = 14'h0E20; eo = 1'b0;
`endif
        issue(14'd200, 14'd100);
        repeat (3) step();
        n_tests++;
        if (dv[0] !== 1'b1 || dq0 !== ed || ov[0] !== eo) begin
            n_fail++; $display("FAIL wrap_200x100: dv=%b dout=%h ovf=%b, expected 1 %h %b", dv[0], dq0, ov[0], ed, eo);
        end
        step();
    endtask

    task automatic test_round();
        issue(14'd25, 14'd1);
        issue(14'h3FE7, 14'd1);
        step();
        n_tests++;
        if (dv[1] !== 1'b1 || dq1 !== 14'd1 || dv[2] !== 1'b1 || dq2 !== 14'd2) begin
            n_fail++; $display("FAIL round_pos: dout1=%h dout2=%h, expected 0001 0002", dq1, dq2);
        end
        step();
        n_tests++;
        if (dq1 !== 14'h3FFE || dq2 !== 14'h3FFE) begin
            n_fail++; $display("FAIL round_neg: dout1=%h dout2=%h, expected 3ffe 3ffe", dq1, dq2);
        end
        repeat (2) step();
    endtask

    task automatic test_stall();
        issue(14'd7, 14'd9);
        step();
        ce = 1'b0;
        repeat (3) step();
        n_tests++;
        if (dv[0] !== 1'b0) begin n_fail++; $display("FAIL stall_frozen: dv0=%b, expected 0", dv[0]); end
        ce = 1'b1;
        step();
        n_tests++;
        if (dv[0] !== 1'b0) begin n_fail++; $display("FAIL stall_edge6: dv0=%b, expected 0", dv[0]); end
        step();
        n_tests++;
        if (dv[0] !== 1'b1 || dq0 !== 14'd63) begin
            n_fail++; $display("FAIL stall_edge7: dv=%b dout=%h, expected 1 003f", dv[0], dq0);
        end
        ce = 1'b0;
        repeat (2) step();
        n_tests++;
        if (dv[0] !== 1'b1 || dq0 !== 14'd63) begin
            n_fail++; $display("FAIL stall_hold: dv=%b dout=%h, expected 1 003f", dv[0], dq0);
        end
        ce = 1'b1;
        step();
        n_tests++;
        if (dv[0] !== 1'b0) begin n_fail++; $display("FAIL stall_release: dv0=%b, expected 0", dv[0]); end
        repeat (2) step();
    endtask

    task automatic test_back_to_back();
        logic [13:0] va [8];
        logic [13:0] vb [8];
        int          cnt = 0;
        va[0] = 14'h2000; vb[0] = 14'h2000;
        va[1] = 14'h1FFF; vb[1] = 14'h1FFF;
        va[2] = 14'h2000; vb[2] = 14'h1FFF;
        for (int k = 3; k < 8; k++) begin va[k] = 14'($urandom); vb[k] = 14'($urandom); end
        for (int k = 0; k < 8; k++) begin
            din0 = va[k]; din1 = vb[k]; din_valid = 1'b1;
            step();
            cnt += int'(dv[0]);
        end
        din_valid = 1'b0;
        repeat (6) begin step(); cnt += int'(dv[0]); end
        n_tests++;
        if (cnt !== 8) begin n_fail++; $display("FAIL b2b_count: got %0d pulses, expected 8", cnt); end
    endtask

    task automatic test_flush();
        int cnt = 0;
        for (int k = 0; k < 3; k++) issue(14'($urandom), 14'($urandom));
        flush = 1'b1; din_valid = 1'b1; din0 = 14'd5; din1 = 14'd5;
        step();
        flush = 1'b0; din_valid = 1'b0;
        n_tests++;
        if (bz !== 4'b0 || dv !== 4'b0) begin
            n_fail++; $display("FAIL flush_busy: busy=%b dv=%b, expected 0000 0000", bz, dv);
        end
        repeat (6) begin step(); cnt += int'(|dv); end
        n_tests++;
        if (cnt !== 0) begin n_fail++; $display("FAIL flush_silent: got %0d valid cycles, expected 0", cnt); end
    endtask

    task automatic test_reset_mid();
        int k;
        issue(14'd11, 14'd13);
        issue(14'd17, 14'd19);
        #2 reset = 1'b0;
        #1;
        n_tests++;
        if (dv !== 4'b0 || bz !== 4'b0 || dq0 !== 14'h0 || dq3 !== 16'h0) begin
            n_fail++; $display("FAIL reset_mid: dv=%b busy=%b dout0=%h dout3=%h, expected all 0", dv, bz, dq0, dq3);
        end
        step();
        reset = 1'b1;
        issue(14'd6, 14'd7);
        for (k = 2; k < 12; k++) begin
            step();
            if (dv[0]) break;
        end
        n_tests++;
        if (k !== 4 || dq0 !== 14'd42) begin
            n_fail++; $display("FAIL reset_relat: latency %0d dout=%h, expected 4 002a", k, dq0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_round();
        test_stall();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        repeat (4) step();
        n_tests++;
        if (sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size() !== 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d results outstanding, expected 0",
                     sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
